// File: rtl/cfs_md_pkg.sv
// Shared definitions for the MD RX arbiter: arbitration states and the
// offset/size field-width derivation from the MD data width.
package cfs_md_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  // Offset field width; a single-byte bus still carries a 1-bit offset.
  function automatic int offset_w(input int data_width);
    return (data_width <= 8) ? 1 : $clog2(data_width / 8);
  endfunction

  function automatic int size_w(input int data_width);
    return $clog2(data_width / 8) + 1;
  endfunction

endpackage

// File: rtl/cfs_md_rx_arbiter_rr_picker.sv
// Two-way round-robin picker: the pointer decides only when both requesters
// are active; a lone requester always wins.
module cfs_rr_picker (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       idx,
  output logic       any
);

  // Winner index and request-present flag.
  always_comb begin
    any = |req;
    case (req)
      2'b01:   idx = 1'b0;
      2'b10:   idx = 1'b1;
      2'b11:   idx = ptr;
      default: idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/cfs_md_rx_arbiter.sv
// Two-requester arbiter in front of the MD RX aligner port: round-robin grant,
// ownership held until handshake or an abort, saturating per-requester counts.
module cfs_md_rx_arbiter
  import cfs_md_pkg::*;
#(
  parameter  int ALGN_DATA_WIDTH = 32,
  parameter  int CNT_WIDTH       = 16,
  localparam int OFFSET_W        = offset_w(ALGN_DATA_WIDTH),
  localparam int SIZE_W          = size_w(ALGN_DATA_WIDTH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [1:0]                   s_valid,
  input  logic [2*ALGN_DATA_WIDTH-1:0] s_data,
  input  logic [2*OFFSET_W-1:0]        s_offset,
  input  logic [2*SIZE_W-1:0]          s_size,
  output logic [1:0]                   s_ready,
  output logic [1:0]                   s_err,
  output logic                         m_valid,
  output logic [ALGN_DATA_WIDTH-1:0]   m_data,
  output logic [OFFSET_W-1:0]          m_offset,
  output logic [SIZE_W-1:0]            m_size,
  input  logic                         m_ready,
  input  logic                         m_err,
  output logic                         grant_id,
  output logic                         busy,
  output logic                         abort,
  output logic [2*CNT_WIDTH-1:0]       xfer_cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  arb_state_e           state_q, state_d;
  logic                 grant_id_q, grant_id_d;
  logic                 rr_ptr_q, rr_ptr_d;
  logic                 busy_q, busy_d;
  logic [CNT_WIDTH-1:0] cnt_q [2];
  logic [CNT_WIDTH-1:0] cnt_d [2];

  logic pick_idx_s;
  logic pick_any_s;
  logic in_grant_s;
  logic owner_valid_s;
  logic handshake_s;

  cfs_rr_picker u_picker (
    .req (s_valid),
    .ptr (rr_ptr_q),
    .idx (pick_idx_s),
    .any (pick_any_s)
  );

  // Owner status and the completion / violation conditions for this cycle.
  always_comb begin
    in_grant_s    = (state_q == ST_GRANT);
    owner_valid_s = grant_id_q ? s_valid[1] : s_valid[0];
    handshake_s   = in_grant_s && owner_valid_s && m_ready;
  end

  // Shared port mirrors the owner's slice; responses go only to the owner.
  always_comb begin
    m_valid  = in_grant_s && owner_valid_s;
    m_data   = grant_id_q ? s_data[2*ALGN_DATA_WIDTH-1:ALGN_DATA_WIDTH]
                          : s_data[ALGN_DATA_WIDTH-1:0];
    m_offset = grant_id_q ? s_offset[2*OFFSET_W-1:OFFSET_W] : s_offset[OFFSET_W-1:0];
    m_size   = grant_id_q ? s_size[2*SIZE_W-1:SIZE_W] : s_size[SIZE_W-1:0];
    abort    = in_grant_s && !owner_valid_s;
    if (!in_grant_s) begin
      s_ready = 2'b00;
      s_err   = 2'b00;
    end else if (grant_id_q) begin
      s_ready = {m_ready, 1'b0};
      s_err   = {m_err, 1'b0};
    end else begin
      s_ready = {1'b0, m_ready};
      s_err   = {1'b0, m_err};
    end
  end

  // Next-state: arbitrate in IDLE, release ownership on handshake or drop.
  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    rr_ptr_d   = rr_ptr_q;
    cnt_d      = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any_s) begin
          state_d    = ST_GRANT;
          grant_id_d = pick_idx_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (handshake_s) begin
          state_d  = ST_IDLE;
          rr_ptr_d = ~grant_id_q;
          if (cnt_q[grant_id_q] != CNT_MAX) begin
            cnt_d[grant_id_q] = cnt_q[grant_id_q] + CNT_ONE;
          end else begin
            cnt_d[grant_id_q] = CNT_MAX;
          end
        end else if (!owner_valid_s) begin
          state_d  = ST_IDLE;
          rr_ptr_d = ~grant_id_q;
        end else begin
          state_d = ST_GRANT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_GRANT);
  end

  // State, pointer, ownership and counters; reset drops ownership at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      grant_id_q <= 1'b0;
      rr_ptr_q   <= 1'b0;
      busy_q     <= 1'b0;
      cnt_q[0]   <= '0;
      cnt_q[1]   <= '0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      rr_ptr_q   <= rr_ptr_d;
      busy_q     <= busy_d;
      cnt_q[0]   <= cnt_d[0];
      cnt_q[1]   <= cnt_d[1];
    end
  end

  assign grant_id = grant_id_q;
  assign busy     = busy_q;
  assign xfer_cnt = {cnt_q[1], cnt_q[0]};

endmodule

// File: tb/tb_cfs_md_rx_arbiter.sv
// Randomised + directed bench for cfs_md_rx_arbiter: a transfer-level model
// queues expected handshakes/aborts, a negedge monitor pops and compares them.
module tb_cfs_md_rx_arbiter;
  import cfs_md_pkg::*;

  localparam int DW = 32;
  localparam int CW = 3;
  localparam int OW = offset_w(DW);
  localparam int SW = size_w(DW);
  localparam int CMAX = (1 << CW) - 1;

  logic            clk = 1'b0;
  logic            reset;
  logic [1:0]      s_valid;
  logic [2*DW-1:0] s_data;
  logic [2*OW-1:0] s_offset;
  logic [2*SW-1:0] s_size;
  logic [1:0]      s_ready, s_err;
  logic            m_valid, m_ready, m_err;
  logic [DW-1:0]   m_data;
  logic [OW-1:0]   m_offset;
  logic [SW-1:0]   m_size;
  logic            grant_id, busy, abort;
  logic [2*CW-1:0] xfer_cnt;

  cfs_md_rx_arbiter #(.ALGN_DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_data(s_data),
    .s_offset(s_offset), .s_size(s_size), .s_ready(s_ready), .s_err(s_err),
    .m_valid(m_valid), .m_data(m_data), .m_offset(m_offset), .m_size(m_size),
    .m_ready(m_ready), .m_err(m_err), .grant_id(grant_id), .busy(busy),
    .abort(abort), .xfer_cnt(xfer_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          is_abort;
    logic          id;
    logic [DW-1:0] data;
    logic [OW-1:0] off;
    logic [SW-1:0] sz;
    logic          err;
  } ev_t;

  ev_t exp_q[$];
  int  n_pass  = 0;
  int  n_total = 0;

  // Transfer-level model: who owns the port, whose turn it is, counts.
  bit  in_grant;
  bit  owner;
  bit  ptr;
  int  cnt[2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  function automatic logic [2*CW-1:0] model_cnt();
    logic [CW-1:0] c0, c1;
    c0 = CW'(cnt[0]);
    c1 = CW'(cnt[1]);
    return {c1, c0};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    s_valid = 2'b11;
    m_ready = 1'b1;
    m_err = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_abort", abort, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_s_err", s_err, 0);
    chk("rst_xfer_cnt", xfer_cnt, 0);
    s_valid = 2'b00;
    m_ready = 1'b0;
    m_err = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    in_grant = 0; owner = 0; ptr = 0; cnt[0] = 0; cnt[1] = 0;
  endtask

  // One clock cycle: drive inputs, check the cycle's outputs, advance the model.
  task automatic step(input logic [1:0] sv, input logic mr, input logic me);
    logic [31:0] r0, r1;
    logic [DW-1:0] slice;
    ev_t ev;
    @(posedge clk);
    #1;
    r0 = $urandom;
    r1 = $urandom;
    s_valid = sv;
    s_data = {r0, r1};
    s_offset = r0[2*OW-1:0];
    s_size = r1[2*SW-1:0];
    m_ready = mr;
    m_err = me;
    #1;
    chk("busy", busy, in_grant);
    chk("xfer_cnt", xfer_cnt, model_cnt());
    if (in_grant) begin
      slice = owner ? r0 : r1;
      chk("grant_id", grant_id, owner);
      chk("m_valid", m_valid, sv[owner]);
      chk("abort", abort, !sv[owner]);
      if (sv[owner]) chk("m_data", m_data, slice);
      chk("s_ready", s_ready, owner ? {mr, 1'b0} : {1'b0, mr});
      chk("s_err", s_err, owner ? {me, 1'b0} : {1'b0, me});
      if (sv[owner] && mr) begin
        ev.is_abort = 1'b0; ev.id = owner; ev.data = slice; ev.err = me;
        ev.off = owner ? s_offset[2*OW-1:OW] : s_offset[OW-1:0];
        ev.sz  = owner ? s_size[2*SW-1:SW] : s_size[SW-1:0];
        exp_q.push_back(ev);
        if (cnt[owner] < CMAX) cnt[owner]++;
        ptr = !owner;
        in_grant = 0;
      end else if (!sv[owner]) begin
        ev.is_abort = 1'b1; ev.id = owner; ev.data = '0; ev.err = 1'b0;
        ev.off = '0; ev.sz = '0;
        exp_q.push_back(ev);
        ptr = !owner;
        in_grant = 0;
      end
    end else begin
      chk("idle_m_valid", m_valid, 0);
      chk("idle_s_ready", s_ready, 0);
      chk("idle_s_err", s_err, 0);
      chk("idle_abort", abort, 0);
      if (sv != 2'b00) begin
        owner = (sv == 2'b11) ? ptr : sv[1];
        in_grant = 1;
      end
    end
  endtask

  // Monitor: every DUT handshake or abort must match the next queued event.
  always @(negedge clk) begin
    ev_t ev;
    if (!reset && ((m_valid && m_ready) || abort)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_event", 1, 0);
      end else begin
        ev = exp_q.pop_front();
        chk("ev_kind", abort, ev.is_abort);
        chk("ev_id", grant_id, ev.id);
        if (ev.is_abort) begin
          chk("ev_abort_m_valid", m_valid, 0);
        end else begin
          chk("ev_data", m_data, ev.data);
          chk("ev_offset", m_offset, ev.off);
          chk("ev_size", m_size, ev.sz);
          chk("ev_err", s_err[ev.id], ev.err);
          chk("ev_ready", s_ready[ev.id], 1);
        end
      end
    end
  end

  initial begin
    logic [31:0] r;
    logic [1:0] sv;
    s_data = '0; s_offset = '0; s_size = '0;
    do_reset();

    // Single request from requester 0.
    step(2'b01, 1'b1, 1'b0);
    step(2'b01, 1'b1, 1'b0);
    step(2'b00, 1'b0, 1'b0);
    chk("single_cnt", xfer_cnt, {3'd0, 3'd1});

    // Contention: alternating grants.
    do_reset();
    for (int i = 0; i < 8; i++) step(2'b11, 1'b1, 1'b0);
    step(2'b00, 1'b0, 1'b0);
    chk("contention_cnt", xfer_cnt, {3'd2, 3'd2});

    // Backpressure on owner 1.
    do_reset();
    for (int i = 0; i < 6; i++) step(2'b10, 1'b0, 1'b0);
    step(2'b10, 1'b1, 1'b0);
    step(2'b00, 1'b0, 1'b0);
    chk("backpressure_cnt", xfer_cnt, {3'd1, 3'd0});

    // Abort: owner 0 drops after two GRANT cycles, requester 1 is next.
    do_reset();
    for (int i = 0; i < 3; i++) step(2'b01, 1'b0, 1'b0);
    step(2'b10, 1'b0, 1'b0);
    step(2'b10, 1'b0, 1'b0);
    step(2'b10, 1'b1, 1'b0);
    step(2'b00, 1'b0, 1'b0);
    chk("abort_cnt", xfer_cnt, {3'd1, 3'd0});

    // Error with handshake still counts, then saturation of requester 0.
    step(2'b01, 1'b0, 1'b1);
    step(2'b01, 1'b0, 1'b1);
    step(2'b01, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step(2'b01, 1'b0, 1'b0);
      step(2'b01, 1'b1, 1'b0);
    end
    step(2'b00, 1'b0, 1'b0);
    chk("saturate_cnt", xfer_cnt, {3'd1, 3'd7});

    // Asynchronous reset while owning the port.
    step(2'b01, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    s_valid = 2'b01; m_ready = 1'b0;
    #1;
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_m_valid", m_valid, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_m_valid", m_valid, 0);
    chk("async_busy", busy, 0);
    chk("async_cnt", xfer_cnt, 0);
    chk("async_s_ready", s_ready, 0);
    do_reset();

    // Randomised traffic.
    for (int i = 0; i < 500; i++) begin
      r = $urandom;
      sv = r[1:0];
      if (in_grant) sv[owner] = (r[7:4] != 4'd0);
      step(sv, r[8], r[10:9] == 2'b00);
    end
    step(2'b00, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cfs_md_rx_arbiter.md
CFS_MD_RX_ARBITER -- requirements
Module: cfs_md_rx_arbiter

Interface
REQ-001 SHALL have parameter ALGN_DATA_WIDTH, default 32, MD data width in bits, power of two, >= 8.
REQ-002 SHALL have localparam OFFSET_W = (ALGN_DATA_WIDTH<=8) ? 1 : clog2(ALGN_DATA_WIDTH/8), and SIZE_W = clog2(ALGN_DATA_WIDTH/8)+1.
REQ-003 SHALL have parameter CNT_WIDTH, default 16, width of the per-requester transfer counters.
REQ-004 SHALL use one clock and an asynchronous, active-high reset: ports clk and reset, all state clocked on rising clk.
REQ-005 clk  input  1  sole clock.
REQ-006 reset  input  1  asynchronous active-high reset.
REQ-007 s_valid  input  2  per-requester MD valid; bit i = requester i.
REQ-008 s_data  input  2*ALGN_DATA_WIDTH  requester data; slice i = requester i.
REQ-009 s_offset  input  2*OFFSET_W  requester offsets.
REQ-010 s_size  input  2*SIZE_W  requester sizes.
REQ-011 s_ready  output  2  per-requester ready.
REQ-012 s_err  output  2  per-requester error, meaningful only with s_ready.
REQ-013 m_valid, m_data, m_offset, m_size  output  1/ALGN_DATA_WIDTH/OFFSET_W/SIZE_W  shared MD RX port toward the aligner.
REQ-014 m_ready, m_err  input  1/1  aligner response.
REQ-015 grant_id  output  1  index of the current owner, valid while busy=1.
REQ-016 busy  output  1  high while a requester owns the port.
REQ-017 abort  output  1  one-cycle pulse on a protocol-violation abort.
REQ-018 xfer_cnt  output  2*CNT_WIDTH  completed-transfer count per requester, saturating.

Function
REQ-019 SHALL use FSM states IDLE and GRANT.
REQ-020 IDLE: m_valid=0, s_ready=0, s_err=0; if any s_valid is high, register the winner in grant_id and enter GRANT next cycle (one-cycle arbitration latency).
REQ-021 Winner selection SHALL be round-robin: priority pointer rr_ptr, reset 0; if both requesters are valid, pick rr_ptr; if one is valid, pick it.
REQ-022 GRANT: m_valid/m_data/m_offset/m_size SHALL combinationally mirror the owner's slice; s_ready[owner]=m_ready, s_err[owner]=m_err; non-owner s_ready/s_err SHALL stay 0.
REQ-023 The handshake SHALL be the owner's valid & m_ready: return to IDLE next cycle, set rr_ptr = ~owner, increment xfer_cnt[owner], saturating at all-ones.
REQ-024 Ownership SHALL be held across any number of m_ready=0 cycles; no preemption.
REQ-025 If the owner's s_valid drops in GRANT without a handshake: m_valid=0 that cycle, abort=1 for that cycle, return to IDLE, rr_ptr = ~owner, no count increment.
REQ-026 m_err without m_ready SHALL be ignored; m_err with the handshake SHALL still complete the transfer and count it.
REQ-027 The minimum spacing between back-to-back transfers SHALL be 2 cycles (handshake, IDLE arbitration).

Reset
REQ-028 While reset=1: state=IDLE, rr_ptr=0, grant_id=0, busy=0, abort=0, xfer_cnt=0, and m_valid=0, s_ready=0, s_err=0, regardless of the clock.
REQ-029 Reset mid-GRANT SHALL drop ownership immediately; after release, arbitration restarts in IDLE with no abort pulse.

Structure
REQ-030 OFFSET_W/SIZE_W derivation and the state enum SHALL live in the shared package cfs_md_pkg.
REQ-031 SHALL instantiate one sub-module, cfs_rr_picker (2-way round-robin picker: req[1:0] and ptr in, idx and any out).

Verification
REQ-032 Single request: s_valid=01, m_ready=1 from GRANT -> grant_id=0 at cycle 1, handshake at cycle 1, xfer_cnt[0]=1, s_ready=00 at cycle 2.
REQ-033 Contention: s_valid=11 held, m_ready=1 -> grants alternate 0,1,0,1; after 4 transfers xfer_cnt = {2,2}.
REQ-034 Backpressure: owner 1, m_ready=0 for 5 cycles then 1 -> m_data equals s_data slice 1 throughout, s_ready[0]=0 always, exactly one count on requester 1.
REQ-035 Abort: owner 0 drops s_valid after 2 GRANT cycles -> abort pulse of 1 cycle, xfer_cnt[0] unchanged, next grant goes to requester 1 if it is requesting.
REQ-036 Error and saturation: m_err=1 with the handshake -> s_err[owner]=1 in that cycle and the count increments; with CNT_WIDTH=2, 5 transfers -> count stays at 3.
REQ-037 Async reset in GRANT (asserted between clock edges) -> m_valid and busy go to 0 before the next edge, all counters read 0.
